// File: rtl/alu_pkg.sv
// ALU opcode, main-control class and funct3 constants.
// Shared by the operand stage, the ALU and their benches.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_ARITH = 2'b10;

  localparam logic [2:0] FUNCT3_ADD = 3'b000;
  localparam logic [2:0] FUNCT3_AND = 3'b111;
  localparam logic [2:0] FUNCT3_OR  = 3'b110;

  typedef struct packed {
    logic       illegal;
    logic [3:0] op;
  } alu_ctl_t;

endpackage

// File: rtl/alu_operand_stage_reg_file.sv
// Integer register file: 2 read, 1 write, x0 hardwired.
// Reads bypass a same-cycle write (write-first).
module reg_file #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  function automatic logic [XLEN-1:0] rd_port(
    input logic [AW-1:0] a
  );
    if (a == '0)
      return '0;
    if (we && waddr == a)
      return wdata;
    return regs[a];
  endfunction

  assign rdata1 = rd_port(raddr1);
  assign rdata2 = rd_port(raddr2);

endmodule

// File: rtl/alu_operand_stage.sv
// Decode/operand stage: register read, ALU control decode,
// B-mux and a one-entry valid/ready output register.
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [AW-1:0]   rd,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic            alu_src,
  input  logic [XLEN-1:0] imm,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B,
  output logic [3:0]      ALU_operation,
  output logic [AW-1:0]   rd_out,
  output logic            op_illegal
);

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] b_sel;
  alu_ctl_t        ctl;
  logic            accept;

  reg_file #(
    .XLEN(XLEN),
    .NREG(NREG),
    .AW  (AW)
  ) u_rf (
    .clk   (clk),
    .rst   (rst),
    .raddr1(rs1),
    .raddr2(rs2),
    .rdata1(rs1_val),
    .rdata2(rs2_val),
    .we    (wb_en),
    .waddr (wb_addr),
    .wdata (wb_data)
  );

  // ADDI shares funct3 with ADD/SUB; bit 30 only selects SUB for R-type
  always_comb begin
    ctl.op      = ALU_ADD;
    ctl.illegal = 1'b0;
    unique case (alu_op)
      ALUOP_MEM: ctl.op = ALU_ADD;
      ALUOP_BR:  ctl.op = ALU_SUB;
      ALUOP_ARITH: begin
        unique case (funct3)
          FUNCT3_ADD:
            if (funct7_5 && !alu_src)
              ctl.op = ALU_SUB;
          FUNCT3_AND: ctl.op = ALU_AND;
          FUNCT3_OR:  ctl.op = ALU_OR;
          default:    ctl.illegal = 1'b1;
        endcase
      end
      default: ctl.illegal = 1'b1;
    endcase
  end

  assign b_sel    = alu_src ? imm : rs2_val;
  assign in_ready = !out_valid || out_ready || flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      A             <= '0;
      B             <= '0;
      ALU_operation <= ALU_ADD;
      rd_out        <= '0;
      op_illegal    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      A             <= rs1_val;
      B             <= b_sel;
      ALU_operation <= ctl.op;
      rd_out        <= rd;
      op_illegal    <= ctl.illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: vector table,
// directed handshake corners and a randomized reference model.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  rs1, rs2, rd;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic        funct7_5, alu_src;
  logic [31:0] imm;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] A, B;
  logic [3:0]  ALU_operation;
  logic [4:0]  rd_out;
  logic        op_illegal;

  int tests = 0;
  int fails = 0;

  logic [31:0] mreg [32];

  alu_operand_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .alu_op(alu_op), .funct3(funct3),
    .funct7_5(funct7_5), .alu_src(alu_src),
    .imm(imm),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .A(A), .B(B), .ALU_operation(ALU_operation),
    .rd_out(rd_out), .op_illegal(op_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic [1:0]  aop;
    logic [2:0]  f3;
    logic        f75, src;
    logic [31:0] imm;
    logic [31:0] ea, eb;
    logic [3:0]  eop;
    logic        eill;
  } vec_t;

  vec_t vt[11];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // {illegal, opcode} from the decode table
  function automatic logic [4:0] ref_ctl(
    logic [1:0] aop, logic [2:0] f3, logic f75, logic src
  );
    if (aop == 2'd0) return {1'b0, 4'b0010};
    if (aop == 2'd1) return {1'b0, 4'b0110};
    if (aop == 2'd3) return {1'b1, 4'b0010};
    if (f3 == 3'd0)
      return {1'b0, (f75 && !src) ? 4'b0110 : 4'b0010};
    if (f3 == 3'd7) return {1'b0, 4'b0000};
    if (f3 == 3'd6) return {1'b0, 4'b0001};
    return {1'b1, 4'b0010};
  endfunction

  task automatic set_in(logic [4:0] a1, logic [4:0] a2,
                        logic [4:0] d, logic [1:0] aop,
                        logic [2:0] f3, logic f75,
                        logic src, logic [31:0] im);
    rs1 = a1; rs2 = a2; rd = d; alu_op = aop;
    funct3 = f3; funct7_5 = f75; alu_src = src; imm = im;
  endtask

  task automatic wr(logic [4:0] a, logic [31:0] d);
    @(negedge clk);
    in_valid = 1'b0; wb_en = 1'b1; wb_addr = a; wb_data = d;
    @(posedge clk);
    if (a != 0) mreg[a] = d;
    @(negedge clk);
    wb_en = 1'b0;
  endtask

  task automatic issue(logic [4:0] a1, logic [4:0] d);
    @(negedge clk);
    wb_en = 1'b0; flush = 1'b0;
    set_in(a1, 5'd6, d, 2'b10, 3'b000, 1'b0, 1'b0, 32'd0);
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic        m_v, m_ill, ir;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_op;
    logic [4:0]  m_rd, c;
    logic [31:0] sa;

    for (int i = 0; i < 32; i++) mreg[i] = '0;
    rst = 1'b1; in_valid = 0; wb_en = 0; flush = 0;
    out_ready = 0; wb_addr = 0; wb_data = 0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_A", A, 0);
    chk("rst_B", B, 0);
    chk("rst_op", 32'(ALU_operation), 32'h2);
    chk("rst_rd", 32'(rd_out), 0);
    chk("rst_ill", 32'(op_illegal), 0);
    @(negedge clk);
    rst = 1'b0;

    wr(5'd5, 32'd45);
    wr(5'd6, 32'd67);
    wr(5'd0, 32'd99);

    vt[0]  = '{5, 6, 1, 2, 0, 0, 0, 0, 45, 67, 4'b0010, 0};
    vt[1]  = '{5, 6, 2, 2, 0, 1, 0, 0, 45, 67, 4'b0110, 0};
    vt[2]  = '{5, 6, 3, 2, 7, 0, 0, 0, 45, 67, 4'b0000, 0};
    vt[3]  = '{5, 6, 4, 2, 6, 0, 0, 0, 45, 67, 4'b0001, 0};
    vt[4]  = '{5, 6, 5, 2, 1, 0, 0, 0, 45, 67, 4'b0010, 1};
    vt[5]  = '{5, 6, 6, 0, 3, 1, 0, 0, 45, 67, 4'b0010, 0};
    vt[6]  = '{5, 6, 7, 1, 0, 0, 0, 0, 45, 67, 4'b0110, 0};
    vt[7]  = '{5, 6, 8, 3, 0, 0, 0, 0, 45, 67, 4'b0010, 1};
    vt[8]  = '{5, 6, 9, 2, 0, 1, 1, 33, 45, 33, 4'b0010, 0};
    vt[9]  = '{0, 6, 10, 2, 0, 0, 0, 0, 0, 67, 4'b0010, 0};
    vt[10] = '{6, 0, 11, 2, 7, 0, 1, 32'hFFFF_FFF0,
               67, 32'hFFFF_FFF0, 4'b0000, 0};

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      wb_en = 0; flush = 0; in_valid = 1; out_ready = 1;
      set_in(vt[i].rs1, vt[i].rs2, vt[i].rd, vt[i].aop,
             vt[i].f3, vt[i].f75, vt[i].src, vt[i].imm);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 1);
      chk($sformatf("v%0d_A", i), A, vt[i].ea);
      chk($sformatf("v%0d_B", i), B, vt[i].eb);
      chk($sformatf("v%0d_op", i), 32'(ALU_operation),
          32'(vt[i].eop));
      chk($sformatf("v%0d_ill", i), 32'(op_illegal),
          32'(vt[i].eill));
      chk($sformatf("v%0d_rd", i), 32'(rd_out),
          32'(vt[i].rd));
    end
    drain();
    chk("drain_valid", 32'(out_valid), 0);

    // bypass: write x7 and read it in the same cycle
    @(negedge clk);
    wb_en = 1; wb_addr = 7; wb_data = 123;
    set_in(7, 7, 12, 2, 0, 0, 0, 0);
    in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    mreg[7] = 123;
    chk("byp_A", A, 123);
    chk("byp_B", B, 123);
    issue(5'd7, 5'd13);
    chk("stored_x7", A, 123);

    // stall: hold rd=1 for three cycles while rd=2 is offered
    issue(5'd5, 5'd1);
    @(negedge clk);
    out_ready = 0; in_valid = 1;
    set_in(6, 6, 2, 2, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_rd", 32'(rd_out), 1);
      chk("stall_A", A, 45);
      @(negedge clk);
    end
    out_ready = 1;
    #1;
    chk("unstall_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    chk("unstall_rd", 32'(rd_out), 2);
    chk("unstall_A", A, 67);
    drain();
    chk("no_dup_valid", 32'(out_valid), 0);

    // flush drops both the held and the offered instruction
    issue(5'd5, 5'd3);
    @(negedge clk);
    out_ready = 0; flush = 1; in_valid = 1;
    set_in(6, 6, 4, 2, 0, 0, 0, 0);
    #1;
    chk("flush_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    chk("flush_valid", 32'(out_valid), 0);
    @(negedge clk);
    flush = 0; in_valid = 0;
    @(posedge clk); #1;
    chk("flush_valid2", 32'(out_valid), 0);
    chk("flush_rd_held", 32'(rd_out), 3);

    // asynchronous reset in the middle of a stall
    issue(5'd5, 5'd14);
    @(negedge clk);
    out_ready = 0; in_valid = 0;
    #2;
    rst = 1;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    @(negedge clk);
    rst = 0;
    issue(5'd5, 5'd15);
    chk("arst_x5", A, 0);
    drain();

    // randomized traffic against the reference model
    m_v = 0; m_a = 0; m_b = 0; m_op = 4'b0010;
    m_rd = 0; m_ill = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      wb_en     = ($urandom_range(0, 1) == 1);
      wb_addr   = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      set_in(5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)),
             5'($urandom), 2'($urandom), 3'($urandom),
             1'($urandom), 1'($urandom), $urandom);
      #1;
      ir = !m_v || out_ready || flush;
      chk("rnd_in_ready", 32'(in_ready), 32'(ir));
      if (wb_en && wb_addr != 0) mreg[wb_addr] = wb_data;
      if (flush) begin
        m_v = 0;
      end else if (in_valid && ir) begin
        m_v  = 1;
        m_a  = mreg[rs1];
        m_b  = alu_src ? imm : mreg[rs2];
        c    = ref_ctl(alu_op, funct3, funct7_5, alu_src);
        m_op = c[3:0];
        m_ill = c[4];
        m_rd = rd;
      end else if (out_ready) begin
        m_v = 0;
      end
      @(posedge clk); #1;
      chk("rnd_valid", 32'(out_valid), 32'(m_v));
      if (m_v) begin
        sa = A;
        chk("rnd_A", sa, m_a);
        chk("rnd_B", B, m_b);
        chk("rnd_op", 32'(ALU_operation), 32'(m_op));
        chk("rnd_ill", 32'(op_illegal), 32'(m_ill));
        chk("rnd_rd", 32'(rd_out), 32'(m_rd));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
